// File: rtl/nco_pkg.sv
// Shared widths and FSM encoding for the time-multiplexed NCO voice scheduler.
package nco_pkg;
    localparam int ROM_ADDR_W = 5;
    localparam int PHASE_W    = 32;
    localparam int SAMPLE_W   = 16;
    localparam int ACC_W      = 20;
    localparam int MIX_SHIFT  = 3;
    localparam int FRAC_W     = 16;
    localparam int FRAC_LSB   = PHASE_W - ROM_ADDR_W - FRAC_W;

    localparam logic signed [ACC_W-1:0] SAT_HI = 20'sd32767;
    localparam logic signed [ACC_W-1:0] SAT_LO = -20'sd32768;

    typedef enum logic [2:0] {
        IDLE, ADVANCE, FETCH, WAIT_ROM, INTERP, ACCUM, OUTPUT
    } state_t;
endpackage

// File: rtl/nco_interp.sv
// Combinational slope interpolation offset and final mix scale/saturate.
module nco_interp
    import nco_pkg::*;
(
    input  logic signed [SAMPLE_W-1:0] slope,
    input  logic        [FRAC_W-1:0]   frac,
    input  logic signed [ACC_W-1:0]    acc,
    output logic signed [SAMPLE_W-1:0] offset,
    output logic signed [SAMPLE_W-1:0] mix
);
    logic signed [32:0]      prod;
    logic signed [ACC_W-1:0] scaled;

    always_comb begin
        prod   = slope * $signed({1'b0, frac});
        // (slope * frac) >>> 16 always fits 16 bits, so bits [31:16] are the result
        offset = prod[31:16];
        scaled = acc >>> MIX_SHIFT;
        if (scaled > SAT_HI)
            mix = 16'sh7fff;
        else if (scaled < SAT_LO)
            mix = -16'sh8000;
        else
            mix = scaled[SAMPLE_W-1:0];
    end
endmodule

// File: rtl/voice_scheduler.sv
// Sweeps all voices once per sample strobe: advance phase, read shared ROM,
// interpolate, accumulate, then publish one saturated mixed sample.
module voice_scheduler
    import nco_pkg::*;
#(
    parameter  int NUM_VOICES = 8,
    localparam int VIDX_W     = $clog2(NUM_VOICES)
) (
    input  logic                       master_clk,
    input  logic                       rst,
    input  logic                       sample_clk_en,
    input  logic                       cfg_valid,
    output logic                       cfg_ready,
    input  logic [VIDX_W-1:0]          cfg_voice,
    input  logic [PHASE_W-1:0]         cfg_increment,
    input  logic                       cfg_gate,
    output logic [ROM_ADDR_W-1:0]      rom_addr,
    input  logic signed [SAMPLE_W-1:0] rom_sample,
    input  logic signed [SAMPLE_W-1:0] rom_slope,
    output logic signed [SAMPLE_W-1:0] mix_output,
    output logic                       mix_valid,
    output logic                       overrun
);
    state_t                                state;
    logic [NUM_VOICES-1:0][PHASE_W-1:0]    phase;
    logic [NUM_VOICES-1:0][PHASE_W-1:0]    inc;
    logic [NUM_VOICES-1:0]                 gate;
    logic [VIDX_W-1:0]                     vidx;
    logic signed [ACC_W-1:0]               acc;
    logic signed [SAMPLE_W-1:0]            samp_q, off_q, offset, mix_sat;
    logic                                  last_voice;

    assign last_voice = (vidx == VIDX_W'(NUM_VOICES - 1));
    assign cfg_ready  = (state == IDLE);
    assign rom_addr   = (state == FETCH || state == WAIT_ROM)
                        ? phase[vidx][PHASE_W-1 -: ROM_ADDR_W] : '0;

    nco_interp u_interp (
        .slope  (rom_slope),
        .frac   (phase[vidx][FRAC_LSB +: FRAC_W]),
        .acc    (acc),
        .offset (offset),
        .mix    (mix_sat)
    );

    always_ff @(posedge master_clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            phase      <= '0;
            inc        <= '0;
            gate       <= '0;
            vidx       <= '0;
            acc        <= '0;
            samp_q     <= '0;
            off_q      <= '0;
            mix_output <= '0;
            mix_valid  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            mix_valid <= 1'b0;
            if (sample_clk_en && state != IDLE)
                overrun <= 1'b1;
            case (state)
                IDLE: begin
                    // config lands at this edge, so a same-cycle strobe sweeps the new values
                    if (cfg_valid) begin
                        inc[cfg_voice]  <= cfg_increment;
                        gate[cfg_voice] <= cfg_gate;
                        if (!cfg_gate || !gate[cfg_voice])
                            phase[cfg_voice] <= '0;
                    end
                    if (sample_clk_en) begin
                        acc   <= '0;
                        vidx  <= '0;
                        state <= ADVANCE;
                    end
                end
                ADVANCE: begin
                    if (gate[vidx]) begin
                        phase[vidx] <= phase[vidx] + inc[vidx];
                        state       <= FETCH;
                    end else if (last_voice) begin
                        state <= OUTPUT;
                    end else begin
                        vidx <= vidx + 1'b1;
                    end
                end
                FETCH:    state <= WAIT_ROM;
                WAIT_ROM: state <= INTERP;
                INTERP: begin
                    samp_q <= rom_sample;
                    off_q  <= offset;
                    state  <= ACCUM;
                end
                ACCUM: begin
                    acc <= acc
                         + {{(ACC_W-SAMPLE_W){samp_q[SAMPLE_W-1]}}, samp_q}
                         + {{(ACC_W-SAMPLE_W){off_q[SAMPLE_W-1]}}, off_q};
                    if (last_voice) begin
                        state <= OUTPUT;
                    end else begin
                        vidx  <= vidx + 1'b1;
                        state <= ADVANCE;
                    end
                end
                OUTPUT: begin
                    mix_output <= mix_sat;
                    mix_valid  <= 1'b1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_voice_scheduler.sv
// Self-checking bench: directed cases plus random sweeps against an arithmetic voice model.
module tb_voice_scheduler;
    localparam int N = 8;

    logic               master_clk = 0;
    logic               rst = 0;
    logic               sample_clk_en = 0;
    logic               cfg_valid = 0;
    logic               cfg_ready;
    logic [2:0]         cfg_voice = 0;
    logic [31:0]        cfg_increment = 0;
    logic               cfg_gate = 0;
    logic [4:0]         rom_addr;
    logic signed [15:0] rom_sample, rom_slope;
    logic signed [15:0] mix_output;
    logic               mix_valid;
    logic               overrun;

    int total = 0;
    int bad = 0;

    logic signed [15:0] rom_s  [32];
    logic signed [15:0] rom_sl [32];
    logic [31:0]        phase_m [N];
    logic [31:0]        inc_m   [N];
    bit                 gate_m  [N];
    bit                 ovr_m = 0;

    voice_scheduler #(.NUM_VOICES(N)) dut (
        .master_clk    (master_clk),
        .rst           (rst),
        .sample_clk_en (sample_clk_en),
        .cfg_valid     (cfg_valid),
        .cfg_ready     (cfg_ready),
        .cfg_voice     (cfg_voice),
        .cfg_increment (cfg_increment),
        .cfg_gate      (cfg_gate),
        .rom_addr      (rom_addr),
        .rom_sample    (rom_sample),
        .rom_slope     (rom_slope),
        .mix_output    (mix_output),
        .mix_valid     (mix_valid),
        .overrun       (overrun)
    );

    always #5 master_clk = ~master_clk;

    // synchronous ROM: data one cycle after address
    always @(posedge master_clk) begin
        rom_sample <= rom_s[rom_addr];
        rom_slope  <= rom_sl[rom_addr];
    end

    task automatic chk(input string tag, input longint got, input longint exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int v = 0; v < N; v++) begin
            phase_m[v] = 0; inc_m[v] = 0; gate_m[v] = 0;
        end
        ovr_m = 0;
    endtask

    task automatic model_cfg(input int v, input logic [31:0] i, input bit g);
        if (!g || !gate_m[v]) phase_m[v] = 0;
        inc_m[v]  = i;
        gate_m[v] = g;
    endtask

    // one sweep in plain arithmetic: expected mix, latency and first nonzero ROM address
    task automatic model_sweep(output longint mix, output int lat, output int faddr);
        longint acc, s, sl, fr, off;
        int g, a;
        acc = 0; g = 0; faddr = -1;
        for (int v = 0; v < N; v++) begin
            if (gate_m[v]) begin
                g++;
                phase_m[v] = phase_m[v] + inc_m[v];
                a   = int'(longint'(phase_m[v]) / 134217728);
                fr  = (longint'(phase_m[v]) / 2048) % 65536;
                s   = longint'(rom_s[a]);
                sl  = longint'(rom_sl[a]);
                off = (sl * fr) >>> 16;
                acc = acc + s + off;
                if (faddr < 0 && a != 0) faddr = a;
            end
        end
        mix = acc >>> 3;
        if (mix > 32767) mix = 32767;
        else if (mix < -32768) mix = -32768;
        lat = 5 * g + (N - g) + 2;
    endtask

    task automatic do_cfg(input int v, input logic [31:0] i, input bit g);
        @(negedge master_clk);
        chk("cfg_ready_idle", cfg_ready, 1);
        cfg_valid = 1; cfg_voice = 3'(v); cfg_increment = i; cfg_gate = g;
        model_cfg(v, i, g);
        @(posedge master_clk);
        #1 cfg_valid = 0;
    endtask

    task automatic sweep(input int extra_at, input bit with_cfg, input int cv,
                         input logic [31:0] ci, input bit cg,
                         output longint mix_obs, output int lat_obs, output int faddr_obs);
        longint exp_mix;
        int exp_lat, exp_fa, cyc, lowcnt;
        bit got;
        @(negedge master_clk);
        if (with_cfg) begin
            cfg_valid = 1; cfg_voice = 3'(cv); cfg_increment = ci; cfg_gate = cg;
            model_cfg(cv, ci, cg);
        end
        model_sweep(exp_mix, exp_lat, exp_fa);
        if (extra_at > 0 && extra_at < exp_lat) ovr_m = 1;
        sample_clk_en = 1;
        cyc = 0; got = 0; lowcnt = 0; faddr_obs = -1;
        while (!got && cyc < 200) begin
            @(negedge master_clk);
            cyc++;
            cfg_valid = 0;
            sample_clk_en = (cyc == extra_at);
            if (!cfg_ready) lowcnt++;
            if (rom_addr != 0 && faddr_obs < 0) faddr_obs = int'(rom_addr);
            if (mix_valid) got = 1;
        end
        sample_clk_en = 0;
        mix_obs = longint'(mix_output);
        lat_obs = cyc;
        chk("valid_seen", got, 1);
        chk("latency", cyc, exp_lat);
        chk("mix", mix_obs, exp_mix);
        chk("ready_low_cycles", lowcnt, exp_lat - 1);
        chk("first_rom_addr", faddr_obs, exp_fa);
        chk("overrun", overrun, ovr_m);
        @(negedge master_clk);
        chk("valid_one_cycle", mix_valid, 0);
        chk("mix_hold", mix_output, exp_mix);
    endtask

    initial begin
        longint m;
        int l, fa, cnt;
        for (int i = 0; i < 32; i++) begin
            rom_s[i] = 16'(i * 1000); rom_sl[i] = 0;
        end
        model_reset();
        repeat (3) @(negedge master_clk);
        rst = 1;
        @(negedge master_clk);
        chk("rst_cfg_ready", cfg_ready, 1);
        chk("rst_mix_output", mix_output, 0);
        chk("rst_mix_valid", mix_valid, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_rom_addr", rom_addr, 0);

        // single voice, no slope
        do_cfg(0, 32'h0800_0000, 1);
        sweep(0, 0, 0, 0, 0, m, l, fa);
        chk("single_mix", m, 125);
        chk("single_lat", l, 14);
        chk("single_addr", fa, 1);

        // interpolation at half fraction
        rom_sl[0] = 1024;
        do_cfg(0, 32'h0400_0000, 0);
        do_cfg(0, 32'h0400_0000, 1);
        sweep(0, 0, 0, 0, 0, m, l, fa);
        chk("interp_mix", m, 64);

        // gate off, empty sweep, then re-gate from phase 0
        do_cfg(0, 32'h3800_0000, 0);
        sweep(0, 0, 0, 0, 0, m, l, fa);
        chk("muted_lat", l, 10);
        chk("muted_mix", m, 0);
        do_cfg(0, 32'h3800_0000, 1);
        sweep(0, 0, 0, 0, 0, m, l, fa);
        chk("regate_addr", fa, 7);

        // config and strobe in the same cycle
        sweep(0, 1, 3, 32'h1000_0000, 1, m, l, fa);
        chk("same_cycle_lat", l, 18);

        // saturation with all voices gated
        for (int i = 0; i < 32; i++) begin
            rom_s[i] = 16'sh7fff; rom_sl[i] = 16'sh7fff;
        end
        for (int v = 0; v < N; v++) do_cfg(v, 32'h0400_0000, 0);
        for (int v = 0; v < N; v++) do_cfg(v, 32'h0400_0000, 1);
        sweep(0, 0, 0, 0, 0, m, l, fa);
        chk("sat_mix", m, 32767);
        chk("sat_lat", l, 42);

        // strobe mid-sweep is dropped and flagged
        sweep(20, 0, 0, 0, 0, m, l, fa);
        chk("overrun_set", overrun, 1);
        cnt = 0;
        repeat (60) begin
            @(negedge master_clk);
            if (mix_valid) cnt++;
        end
        chk("overrun_no_second_valid", cnt, 0);

        // reset in the middle of a sweep
        @(negedge master_clk);
        sample_clk_en = 1;
        @(negedge master_clk);
        sample_clk_en = 0;
        repeat (6) @(negedge master_clk);
        rst = 0;
        @(negedge master_clk);
        chk("midrst_mix_output", mix_output, 0);
        chk("midrst_overrun", overrun, 0);
        chk("midrst_cfg_ready", cfg_ready, 1);
        chk("midrst_mix_valid", mix_valid, 0);
        chk("midrst_rom_addr", rom_addr, 0);
        rst = 1;
        model_reset();
        cnt = 0;
        repeat (60) begin
            @(negedge master_clk);
            if (mix_valid) cnt++;
        end
        chk("midrst_no_valid", cnt, 0);

        // random sweeps
        for (int it = 0; it < 20; it++) begin
            for (int i = 0; i < 32; i++) begin
                rom_s[i] = 16'($urandom); rom_sl[i] = 16'($urandom);
            end
            for (int k = $urandom_range(0, 3); k > 0; k--)
                do_cfg($urandom_range(0, N - 1), $urandom, 1'($urandom_range(0, 1)));
            sweep(0, 1'($urandom_range(0, 1)), $urandom_range(0, N - 1), $urandom,
                  1'($urandom_range(0, 1)), m, l, fa);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
